alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Pipeline register stage directly upstream of the ALU.
//  - Accepts decoded operands over a valid/ready handshake.
//  - Resolves EX/MEM and MEM/WB forwarding and the immediate select at capture time.
//  - Presents registered src1/src2/ctrl to the ALU one cycle later.
//  - Supports backpressure, flush and a saturating stall counter.
// PARAMETERS
//  DATA_W  32  operand/result width
//  ADDR_W  5   register address width
//  CNT_W   16  stall counter width
// PORTS
//  clk_i              in   1       clock, rising edge
//  rst_i              in   1       asynchronous reset, active-high
//  in_valid_i         in   1       upstream presents an instruction
//  in_ready_o         out  1       stage can accept this cycle
//  rs_addr_i          in   ADDR_W  source register 1 index
//  rt_addr_i          in   ADDR_W  source register 2 index
//  rs_data_i          in   DATA_W  register-file read data for rs
//  rt_data_i          in   DATA_W  register-file read data for rt
//  imm_i              in   DATA_W  sign-extended immediate
//  alu_src_i          in   1       1: src2 = imm_i; 0: src2 = forwarded rt
//  alu_ctrl_i         in   4       ALU opcode
//  rd_addr_i          in   ADDR_W  destination register
//  reg_write_i        in   1       instruction writes rd
//  exmem_wr_i         in   1       EX/MEM stage writes its rd
//  exmem_rd_i         in   ADDR_W  EX/MEM destination
//  exmem_data_i       in   DATA_W  EX/MEM result
//  memwb_wr_i         in   1       MEM/WB stage writes its rd
//  memwb_rd_i         in   ADDR_W  MEM/WB destination
//  memwb_data_i       in   DATA_W  MEM/WB result
//  flush_i            in   1       kill held and incoming instruction
//  out_valid_o        out  1       src1_o/src2_o/ctrl_o are valid
//  out_ready_i        in   1       ALU side consumes this cycle
//  src1_o             out  DATA_W  ALU operand 1
//  src2_o             out  DATA_W  ALU operand 2
//  ctrl_o             out  4       ALU opcode
//  rd_addr_o          out  ADDR_W  destination, passed through
//  reg_write_o        out  1       write enable; forced 0 when out_valid_o=0
//  ctrl_illegal_o     out  1       held ctrl not in {0000,0001,0010,0110,0111}
//  stall_cnt_o        out  CNT_W   cycles with out_valid_o & ~out_ready_i
// BEHAVIOUR
//  Reset: every output and register goes to 0 immediately (asynchronous). Exception: in_ready_o=1.
//  Handshake:
//  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
//  - Accept = in_valid_i & in_ready_o & ~flush_i.
//  - Latency: 1 cycle, accept -> out_valid_o. Full throughput when out_ready_i is held at 1.
//  Edge update:
//  - accept: load all output registers; out_valid_o <= 1.
//  - else if out_ready_i: out_valid_o <= 0.
//  - else: hold.
//  - Outputs never change while out_valid_o=1 and out_ready_i=0.
//  Forwarding, applied per operand at capture:
//  - EX/MEM wins if exmem_wr_i and exmem_rd_i == addr.
//  - Else MEM/WB wins if memwb_wr_i and memwb_rd_i == addr.
//  - Else register-file data.
//  - Address 0 is never forwarded; it always uses the register-file data (read as 0).
//  - src2 selects imm_i when alu_src_i=1, ignoring rt forwarding.
//  flush_i: out_valid_o <= 0 and incoming data is dropped; this overrides accept and hold.
//  ctrl_illegal_o: registered with ctrl_o. ctrl_o is still passed unchanged.
//  stall_cnt_o: +1 on each cycle with out_valid_o=1 and out_ready_i=0.
//  - Saturates at all-ones; never wraps.
//  - Clears only on reset.
// TESTING
//  T1 reset mid-stream: out_valid_o=1, assert rst_i between edges -> all outputs 0 at once; in_ready_o=1.
//  T2 forward priority: rs=3; exmem wr rd3=0x11; memwb wr rd3=0x22; rs_data=0x33
//     -> src1_o=0x11.
//     Same with exmem_wr_i=0 -> 0x22.
//     With rs=0 -> rs_data_i.
//  T3 backpressure: accept A (src1=5), hold out_ready_i=0 three cycles, offer B
//     -> in_ready_o=0; A held; stall_cnt_o=3.
//     Then ready=1 -> B appears on the next cycle.
//  T4 flush vs accept: in_valid_i=1 and flush_i=1 on the same edge
//     -> out_valid_o=0; held data is not presented.
//  T5 immediate + illegal op: alu_src_i=1, imm=0xFFFFFFFC, ctrl=0011
//     -> src2_o=0xFFFFFFFC, ctrl_o=0011, ctrl_illegal_o=1.
//  T6 counter saturation: CNT_W=4, stall 20 cycles -> stall_cnt_o=15 and stays 15.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
//   Bundle of every non-clock/reset signal of the ALU issue stage.
//   Signal names keep the stage's point of view (_i = into the stage,
//   _o = out of the stage).
//   Modports:
//     slave  - the issue stage itself
//     master - whoever drives the decode side and consumes the ALU side
//   Groups:
//     upstream handshake : in_valid_i / in_ready_o
//     decoded operands   : rs/rt addr+data, imm_i, alu_src_i, alu_ctrl_i,
//                          rd_addr_i, reg_write_i
//     forwarding sources : exmem_* and memwb_*
//     control            : flush_i
//     downstream         : out_valid_o / out_ready_i, src1_o, src2_o, ctrl_o,
//                          rd_addr_o, reg_write_o, ctrl_illegal_o, stall_cnt_o
// ---------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic              alu_src_i;
    logic [3:0]        alu_ctrl_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              reg_write_i;
    logic              exmem_wr_i;
    logic [ADDR_W-1:0] exmem_rd_i;
    logic [DATA_W-1:0] exmem_data_i;
    logic              memwb_wr_i;
    logic [ADDR_W-1:0] memwb_rd_i;
    logic [DATA_W-1:0] memwb_data_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] src1_o;
    logic [DATA_W-1:0] src2_o;
    logic [3:0]        ctrl_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              reg_write_o;
    logic              ctrl_illegal_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  in_valid_i, rs_addr_i, rt_addr_i, rs_data_i, rt_data_i, imm_i,
               alu_src_i, alu_ctrl_i, rd_addr_i, reg_write_i,
               exmem_wr_i, exmem_rd_i, exmem_data_i,
               memwb_wr_i, memwb_rd_i, memwb_data_i,
               flush_i, out_ready_i,
        output in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, rd_addr_o,
               reg_write_o, ctrl_illegal_o, stall_cnt_o
    );

    modport master (
        output in_valid_i, rs_addr_i, rt_addr_i, rs_data_i, rt_data_i, imm_i,
               alu_src_i, alu_ctrl_i, rd_addr_i, reg_write_i,
               exmem_wr_i, exmem_rd_i, exmem_data_i,
               memwb_wr_i, memwb_rd_i, memwb_data_i,
               flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, rd_addr_o,
               reg_write_o, ctrl_illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Pipeline register directly in front of the ALU. Captures a decoded
//   instruction over a valid/ready handshake, resolving EX/MEM and MEM/WB
//   forwarding and the immediate select at capture time, and presents
//   registered operands/opcode to the ALU one cycle later.
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - asynchronous reset, active-high
//     bus    - alu_issue_stage_if.slave (handshakes, operands, forwarding
//              sources, flush, ALU-side outputs, stall counter)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_issue_stage_if.slave  bus
);

    // Registered state
    logic              r_out_valid;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [3:0]        r_ctrl;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_reg_write;
    logic              r_ctrl_illegal;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Combinational
    logic              w_in_ready;
    logic              w_accept;
    logic              w_stalled;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_rt_fwd;
    logic [DATA_W-1:0] w_src2;
    logic              w_ctrl_illegal;

    // A slot frees up either when empty or when the ALU drains it this cycle.
    assign w_in_ready = ~r_out_valid | bus.out_ready_i;
    assign w_accept   = bus.in_valid_i & w_in_ready & ~bus.flush_i;
    assign w_stalled  = r_out_valid & ~bus.out_ready_i;

    // Forwarding: EX/MEM is younger than MEM/WB, so it takes priority.
    // Register 0 is hard-wired, so a writer targeting it must never win.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_src1 = bus.rs_data_i;
        if (bus.rs_addr_i != '0) begin
            if (bus.exmem_wr_i && (bus.exmem_rd_i == bus.rs_addr_i))
                w_src1 = bus.exmem_data_i;
            else if (bus.memwb_wr_i && (bus.memwb_rd_i == bus.rs_addr_i))
                w_src1 = bus.memwb_data_i;
        end
    end

    always_comb begin
        w_rt_fwd = bus.rt_data_i;
        if (bus.rt_addr_i != '0) begin
            if (bus.exmem_wr_i && (bus.exmem_rd_i == bus.rt_addr_i))
                w_rt_fwd = bus.exmem_data_i;
            else if (bus.memwb_wr_i && (bus.memwb_rd_i == bus.rt_addr_i))
                w_rt_fwd = bus.memwb_data_i;
        end
    end

    // The immediate bypasses rt forwarding entirely.
    assign w_src2 = bus.alu_src_i ? bus.imm_i : w_rt_fwd;

    // Opcodes the ALU implements: AND, OR, ADD, SUB, SLT.
    assign w_ctrl_illegal = !(bus.alu_ctrl_i inside {4'b0000, 4'b0001, 4'b0010,
                                                     4'b0110, 4'b0111});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: datapath registers are reset too so the ALU never sees X
            // operands straight out of reset.
            r_out_valid    <= 1'b0;
            r_src1         <= '0;
            r_src2         <= '0;
            r_ctrl         <= '0;
            r_rd_addr      <= '0;
            r_reg_write    <= 1'b0;
            r_ctrl_illegal <= 1'b0;
            r_stall_cnt    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            // Flush kills both the held and the incoming instruction.
            if (bus.flush_i) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid    <= 1'b1;
                r_src1         <= w_src1;
                r_src2         <= w_src2;
                r_ctrl         <= bus.alu_ctrl_i;
                r_rd_addr      <= bus.rd_addr_i;
                r_reg_write    <= bus.reg_write_i;
                r_ctrl_illegal <= w_ctrl_illegal;
            end else if (bus.out_ready_i) begin
                r_out_valid <= 1'b0;
            end

            // Saturating: stops at all-ones instead of wrapping.
            if (w_stalled && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready_o     = w_in_ready;
    assign bus.out_valid_o    = r_out_valid;
    assign bus.src1_o         = r_src1;
    assign bus.src2_o         = r_src2;
    assign bus.ctrl_o         = r_ctrl;
    assign bus.rd_addr_o      = r_rd_addr;
    // A stale write enable must never escape an empty slot.
    assign bus.reg_write_o    = r_reg_write & r_out_valid;
    assign bus.ctrl_illegal_o = r_ctrl_illegal;
    assign bus.stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed bench for alu_issue_stage. Expected ALU-side results are pushed
//   to a scoreboard queue when an instruction is driven and popped when the
//   stage presents it. CNT_W is 4 so counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    alu_issue_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    alu_issue_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [31:0] rs_d,
                         input logic [4:0] rt, input logic [31:0] rt_d,
                         input logic [31:0] imm, input logic src,
                         input logic [3:0] ctrl, input logic [4:0] rd,
                         input logic wr);
        bus.in_valid_i  = 1'b1;
        bus.rs_addr_i   = rs;
        bus.rs_data_i   = rs_d;
        bus.rt_addr_i   = rt;
        bus.rt_data_i   = rt_d;
        bus.imm_i       = imm;
        bus.alu_src_i   = src;
        bus.alu_ctrl_i  = ctrl;
        bus.rd_addr_i   = rd;
        bus.reg_write_i = wr;
    endtask

    task automatic push(input logic [31:0] s1, input logic [31:0] s2,
                        input logic [3:0] c, input logic [4:0] rd,
                        input logic wr, input logic ill);
        exp_t e;
        e.src1 = s1; e.src2 = s2; e.ctrl = c; e.rd = rd; e.wr = wr; e.ill = ill;
        sb_q.push_back(e);
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] md);
        bus.exmem_wr_i = ew; bus.exmem_rd_i = erd; bus.exmem_data_i = ed;
        bus.memwb_wr_i = mw; bus.memwb_rd_i = mrd; bus.memwb_data_i = md;
    endtask

    // Waits (bounded) for a presented instruction and compares it with the
    // oldest scoreboard entry.
    task automatic pop_check(input string tag);
        exp_t e;
        int   waited = 0;
        while (bus.out_valid_o !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check({tag, " valid"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, " pending"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({tag, " src1"}, bus.src1_o, e.src1);
        check({tag, " src2"}, bus.src2_o, e.src2);
        check({tag, " ctrl"}, 32'(bus.ctrl_o), 32'(e.ctrl));
        check({tag, " rd"},   32'(bus.rd_addr_o), 32'(e.rd));
        check({tag, " wr"},   32'(bus.reg_write_o), 32'(e.wr));
        check({tag, " ill"},  32'(bus.ctrl_illegal_o), 32'(e.ill));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"},  32'(bus.out_valid_o), 32'd0);
        check({tag, " ready"},  32'(bus.in_ready_o), 32'd1);
        check({tag, " src1"},   bus.src1_o, 32'd0);
        check({tag, " src2"},   bus.src2_o, 32'd0);
        check({tag, " ctrl"},   32'(bus.ctrl_o), 32'd0);
        check({tag, " rd"},     32'(bus.rd_addr_o), 32'd0);
        check({tag, " wr"},     32'(bus.reg_write_o), 32'd0);
        check({tag, " ill"},    32'(bus.ctrl_illegal_o), 32'd0);
        check({tag, " stall"},  32'(bus.stall_cnt_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid_i = 1'b0;  bus.rs_addr_i = '0;  bus.rt_addr_i = '0;
        bus.rs_data_i = '0;     bus.rt_data_i = '0;  bus.imm_i = '0;
        bus.alu_src_i = 1'b0;   bus.alu_ctrl_i = '0; bus.rd_addr_i = '0;
        bus.reg_write_i = 1'b0; bus.flush_i = 1'b0;  bus.out_ready_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        // T1: reset while an instruction is held under backpressure.
        drive(5'd1, 32'hAB, 5'd2, 32'hCD, 32'd0, 1'b0, 4'b0010, 5'd4, 1'b1);
        push(32'hAB, 32'hCD, 4'b0010, 5'd4, 1'b1, 1'b0);
        tick();
        pop_check("t1_x");
        bus.in_valid_i = 1'b0;
        tick();
        check("t1_stall1", 32'(bus.stall_cnt_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_zero("t1_async_rst");
        #1 rst = 1'b0;
        tick();

        // T2: forwarding priority, register-0 exclusion, rt forwarding.
        bus.out_ready_i = 1'b1;
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        drive(5'd3, 32'h33, 5'd4, 32'h44, 32'h99, 1'b0, 4'b0000, 5'd8, 1'b1);
        push(32'h11, 32'h44, 4'b0000, 5'd8, 1'b1, 1'b0);
        tick();
        pop_check("t2_exmem");
        bus.exmem_wr_i = 1'b0;
        drive(5'd3, 32'h33, 5'd4, 32'h44, 32'h99, 1'b0, 4'b0000, 5'd9, 1'b1);
        push(32'h22, 32'h44, 4'b0000, 5'd9, 1'b1, 1'b0);
        tick();
        pop_check("t2_memwb");
        set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        drive(5'd0, 32'h33, 5'd0, 32'h55, 32'h99, 1'b0, 4'b0001, 5'd10, 1'b1);
        push(32'h33, 32'h55, 4'b0001, 5'd10, 1'b1, 1'b0);
        tick();
        pop_check("t2_zero");
        set_fwd(1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        drive(5'd5, 32'h66, 5'd3, 32'h44, 32'h99, 1'b0, 4'b0111, 5'd11, 1'b0);
        push(32'h66, 32'h22, 4'b0111, 5'd11, 1'b0, 1'b0);
        tick();
        pop_check("t2_rtfwd");
        bus.in_valid_i = 1'b0;
        tick();
        check("t2_drain valid", 32'(bus.out_valid_o), 32'd0);
        check("t2_drain wr", 32'(bus.reg_write_o), 32'd0);

        // T3: backpressure holds A, blocks B, counts three stall cycles.
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.out_ready_i = 1'b0;
        drive(5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 1'b0, 4'b0000, 5'd12, 1'b1);
        push(32'd5, 32'd6, 4'b0000, 5'd12, 1'b1, 1'b0);
        tick();
        pop_check("t3_a");
        drive(5'd1, 32'd9, 5'd2, 32'd10, 32'd0, 1'b0, 4'b0110, 5'd13, 1'b1);
        push(32'd9, 32'd10, 4'b0110, 5'd13, 1'b1, 1'b0);
        #1;
        check("t3_in_ready_blocked", 32'(bus.in_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold src1", bus.src1_o, 32'd5);
            check("t3_hold valid", 32'(bus.out_valid_o), 32'd1);
        end
        check("t3_stall3", 32'(bus.stall_cnt_o), 32'd3);
        bus.out_ready_i = 1'b1;
        #1;
        check("t3_in_ready_open", 32'(bus.in_ready_o), 32'd1);
        tick();
        pop_check("t3_b");
        check("t3_stall_kept", 32'(bus.stall_cnt_o), 32'd3);
        bus.in_valid_i = 1'b0;
        tick();
        check("t3_drain valid", 32'(bus.out_valid_o), 32'd0);

        // T4: flush beats a concurrent accept, and beats a hold.
        bus.out_ready_i = 1'b0;
        drive(5'd1, 32'h70, 5'd2, 32'h71, 32'd0, 1'b0, 4'b0000, 5'd14, 1'b1);
        push(32'h70, 32'h71, 4'b0000, 5'd14, 1'b1, 1'b0);
        tick();
        pop_check("t4_c");
        bus.out_ready_i = 1'b1;
        bus.flush_i = 1'b1;
        drive(5'd1, 32'h80, 5'd2, 32'h81, 32'd0, 1'b0, 4'b0001, 5'd20, 1'b1);
        tick();
        check("t4_flush_accept valid", 32'(bus.out_valid_o), 32'd0);
        check("t4_flush_accept wr", 32'(bus.reg_write_o), 32'd0);
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        tick();
        check("t4_no_late valid", 32'(bus.out_valid_o), 32'd0);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);
        bus.out_ready_i = 1'b0;
        drive(5'd1, 32'h90, 5'd2, 32'h91, 32'd0, 1'b0, 4'b0010, 5'd15, 1'b1);
        push(32'h90, 32'h91, 4'b0010, 5'd15, 1'b1, 1'b0);
        tick();
        pop_check("t4_e");
        bus.in_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        tick();
        check("t4_flush_hold valid", 32'(bus.out_valid_o), 32'd0);
        check("t4_stall4", 32'(bus.stall_cnt_o), 32'd4);
        bus.flush_i = 1'b0;

        // T5: immediate select ignores rt forwarding; illegal opcode flagged.
        bus.out_ready_i = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h22);
        drive(5'd2, 32'hA, 5'd3, 32'h44, 32'hFFFF_FFFC, 1'b1, 4'b0011, 5'd16, 1'b1);
        push(32'hA, 32'hFFFF_FFFC, 4'b0011, 5'd16, 1'b1, 1'b1);
        tick();
        pop_check("t5_imm_illegal");
        drive(5'd2, 32'hB, 5'd3, 32'h44, 32'hFFFF_FFFC, 1'b0, 4'b0110, 5'd17, 1'b1);
        push(32'hB, 32'h22, 4'b0110, 5'd17, 1'b1, 1'b0);
        tick();
        pop_check("t5_legal");
        bus.in_valid_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        // T6: long stall saturates the 4-bit counter at 15 (4 + 20 > 15).
        bus.out_ready_i = 1'b0;
        drive(5'd1, 32'hF0, 5'd2, 32'hF1, 32'd0, 1'b0, 4'b0010, 5'd18, 1'b1);
        push(32'hF0, 32'hF1, 4'b0010, 5'd18, 1'b1, 1'b0);
        tick();
        pop_check("t6_f");
        bus.in_valid_i = 1'b0;
        repeat (20) tick();
        check("t6_sat", 32'(bus.stall_cnt_o), 32'd15);
        check("t6_hold src1", bus.src1_o, 32'hF0);
        repeat (3) tick();
        check("t6_sat_stays", 32'(bus.stall_cnt_o), 32'd15);
        bus.out_ready_i = 1'b1;
        tick();
        check("t6_drain valid", 32'(bus.out_valid_o), 32'd0);
        check("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
